// File: rtl/call_frame_ctrl_pkg.sv
// call_frame_ctrl_pkg: request, response, state and SuperStack op/status encodings for call_frame_ctrl
package call_frame_ctrl_pkg;
  localparam logic OP_CALL = 1'b0;
  localparam logic OP_RETURN = 1'b1;
  typedef enum logic [2:0] {
    RSP_OK = 3'd0,
    RSP_FRAME_OVERFLOW = 3'd1,
    RSP_FRAME_UNDERFLOW = 3'd2,
    RSP_BAD_ARGS = 3'd3,
    RSP_BAD_RESULTS = 3'd4,
    RSP_STACK_ERROR = 3'd5
  } rsp_status_t;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALL_SET = 3'd1,
    RET_FETCH = 3'd2,
    RET_TRIM = 3'd3,
    RET_DONE = 3'd4,
    RESP = 3'd5
  } state_t;
  localparam logic [2:0] STK_NONE = 3'd0;
  localparam logic [2:0] STK_PUSH = 3'd1;
  localparam logic [2:0] STK_POP = 3'd2;
  localparam logic [2:0] STK_INDEX_RESET = 3'd3;
  localparam logic [2:0] STK_INDEX_RESET_AND_PUSH = 3'd4;
  localparam logic [2:0] STK_ST_OK = 3'd0;
  localparam logic [2:0] STK_ST_OVERFLOW = 3'd1;
  localparam logic [2:0] STK_ST_UNDERFLOW = 3'd2;
  localparam logic [2:0] STK_ST_BAD_INDEX = 3'd3;
endpackage

// File: rtl/call_frame_ctrl_frame_mem.sv
// frame_mem: synchronous LIFO of {limit, ret_addr} frames, 2^FRAMES deep, with count output
module frame_mem #(
  parameter int W = 24,
  parameter int FRAMES = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [W-1:0]      din,
  output logic [W-1:0]      top,
  output logic [FRAMES:0]   count
);
  logic [W-1:0] mem [2**FRAMES];
  assign top = mem[count[FRAMES-1:0] - FRAMES'(1)];
  always_ff @(posedge clk)
    if (push) mem[count[FRAMES-1:0]] <= din;
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else count <= count + (FRAMES+1)'(push) - (FRAMES+1)'(pop);
endmodule

// File: rtl/call_frame_ctrl.sv
// call_frame_ctrl: CALL/RETURN sequencer fencing SuperStack frames; CALL_FRAME_RESULT_CHECK_EN enables the RETURN result-count check
module call_frame_ctrl
  import call_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 7,
  parameter int FRAMES = 5,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [DEPTH:0]        req_args,
  input  logic                  req_results,
  input  logic [ADDR_WIDTH-1:0] req_ret_addr,
  output logic                  rsp_valid,
  output logic [2:0]            rsp_status,
  output logic [ADDR_WIDTH-1:0] rsp_ret_addr,
  output logic                  stk_busy,
  output logic [2:0]            stk_op,
  output logic [WIDTH-1:0]      stk_data,
  output logic [DEPTH:0]        stk_new_index,
  output logic [DEPTH:0]        stk_underflow_limit,
  input  logic [DEPTH:0]        stk_index,
  input  logic [WIDTH-1:0]      stk_out,
  input  logic [2:0]            stk_status
);
  localparam int IW = DEPTH + 1;
  localparam int FW = IW + ADDR_WIDTH;
  state_t state, state_nx;
  rsp_status_t rsp_code, fail_code;
  logic [IW-1:0] limit, base, avail;
  logic [ADDR_WIDTH-1:0] ret_addr;
  logic [FW-1:0] top;
  logic [FRAMES:0] count;
  logic results, accept, push, pop, bad_res;
  frame_mem #(.W(FW), .FRAMES(FRAMES)) u_frames (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din({limit, ret_addr}),
    .top(top),
    .count(count)
  );
  assign avail = stk_index - limit;
  assign accept = req_valid && req_ready;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign stk_busy = state != IDLE && state != RESP;
  assign rsp_status = rsp_code;
  assign stk_underflow_limit = limit;
`ifdef CALL_FRAME_RESULT_CHECK_EN
  assign bad_res = avail != IW'(req_results);
`else
  assign bad_res = 1'b0;
`endif
  // first failing check wins; comparing before subtracting keeps the new limit from wrapping
  assign fail_code = req_op == OP_CALL
    ? (count[FRAMES] ? RSP_FRAME_OVERFLOW : req_args > avail ? RSP_BAD_ARGS : RSP_OK)
    : (count == '0 ? RSP_FRAME_UNDERFLOW : bad_res ? RSP_BAD_RESULTS : RSP_OK);
  always_comb begin
    state_nx = state;
    stk_op = STK_NONE;
    stk_data = '0;
    stk_new_index = '0;
    push = 1'b0;
    pop = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = fail_code != RSP_OK ? RESP : req_op == OP_CALL ? CALL_SET : RET_FETCH;
      CALL_SET: begin
        push = 1'b1;
        state_nx = RESP;
      end
      RET_FETCH: state_nx = RET_TRIM;
      RET_TRIM: begin
        pop = 1'b1;
        stk_op = results ? STK_INDEX_RESET_AND_PUSH : STK_INDEX_RESET;
        stk_data = results ? stk_out : '0;
        stk_new_index = limit;
        state_nx = RET_DONE;
      end
      RET_DONE: state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      limit <= '0;
      base <= '0;
      results <= 1'b0;
      ret_addr <= '0;
      rsp_code <= RSP_OK;
      rsp_ret_addr <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        base <= stk_index - req_args;
        results <= req_results;
        ret_addr <= req_ret_addr;
        if (fail_code != RSP_OK) rsp_code <= fail_code;
      end
      if (push) begin
        limit <= base;
        rsp_code <= RSP_OK;
      end
      if (pop) begin
        limit <= top[FW-1 -: IW];
        rsp_ret_addr <= top[ADDR_WIDTH-1:0];
      end
      if (state == RET_DONE)
        rsp_code <= stk_status == STK_ST_OVERFLOW || stk_status == STK_ST_BAD_INDEX ? RSP_STACK_ERROR : RSP_OK;
    end
endmodule

// File: tb/tb_call_frame_ctrl.sv
// tb_call_frame_ctrl: randomized check of call_frame_ctrl against a frame/stack reference model
module tb_call_frame_ctrl;
  import call_frame_ctrl_pkg::*;
  localparam int WIDTH = 32, DEPTH = 7, FRAMES = 5, AW = 16, IW = DEPTH + 1, CAP = 128, NF = 32;
`ifdef CALL_FRAME_RESULT_CHECK_EN
  localparam bit RCHK = 1'b1;
`else
  localparam bit RCHK = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_op = 1'b0, req_results = 1'b0;
  logic [IW-1:0] req_args = '0;
  logic [AW-1:0] req_ret_addr = '0;
  logic req_ready, rsp_valid, stk_busy;
  logic [2:0] rsp_status, stk_op, stk_status;
  logic [AW-1:0] rsp_ret_addr;
  logic [WIDTH-1:0] stk_data, stk_out;
  logic [IW-1:0] stk_new_index, stk_underflow_limit, stk_index;
  logic [2:0] tb_op = STK_NONE;
  logic [WIDTH-1:0] tb_data = '0;
  call_frame_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_args(req_args), .req_results(req_results), .req_ret_addr(req_ret_addr),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_ret_addr(rsp_ret_addr),
    .stk_busy(stk_busy), .stk_op(stk_op), .stk_data(stk_data), .stk_new_index(stk_new_index),
    .stk_underflow_limit(stk_underflow_limit), .stk_index(stk_index), .stk_out(stk_out),
    .stk_status(stk_status)
  );
  always #5 clk = ~clk;
  // behavioural operand stack, controlled by the DUT while it is busy
  logic [WIDTH-1:0] smem [CAP];
  logic [IW-1:0] sidx = '0;
  logic [2:0] sst = STK_ST_OK;
  logic [2:0] s_op;
  logic [WIDTH-1:0] s_data;
  logic [IW-1:0] s_ni;
  assign s_op = stk_busy ? stk_op : tb_op;
  assign s_data = stk_busy ? stk_data : tb_data;
  assign s_ni = stk_busy ? stk_new_index : '0;
  assign stk_index = sidx;
  assign stk_status = sst;
  assign stk_out = sidx == '0 ? '0 : smem[sidx[DEPTH-1:0] - 7'd1];
  always @(posedge clk)
    if (reset) begin
      sidx <= '0;
      sst <= STK_ST_OK;
    end else begin
      sst <= STK_ST_OK;
      case (s_op)
        STK_PUSH:
          if (sidx == IW'(CAP)) sst <= STK_ST_OVERFLOW;
          else begin smem[sidx[DEPTH-1:0]] <= s_data; sidx <= sidx + 1'b1; end
        STK_INDEX_RESET:
          if (s_ni > sidx) sst <= STK_ST_BAD_INDEX;
          else sidx <= s_ni;
        STK_INDEX_RESET_AND_PUSH:
          if (s_ni > sidx) sst <= STK_ST_BAD_INDEX;
          else if (s_ni == IW'(CAP)) sst <= STK_ST_OVERFLOW;
          else begin smem[s_ni[DEPTH-1:0]] <= s_data; sidx <= s_ni + 1'b1; end
        default: ;
      endcase
    end
  typedef struct { int lim; int addr; } frame_t;
  frame_t frames[$];
  logic [WIDTH-1:0] vals[$];
  int lim = 0;
  int tests = 0, fails = 0;
  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic tb_push(input logic [WIDTH-1:0] v);
    tb_op = STK_PUSH;
    tb_data = v;
    tick();
    tb_op = STK_NONE;
    tb_data = '0;
    vals.push_back(v);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    frames.delete();
    vals.delete();
    lim = 0;
  endtask
  task automatic do_req(input logic op, input int args, input logic res, input int addr);
    int n, elat, eni, eaddr;
    logic [2:0] est, eop, sop;
    logic [WIDTH-1:0] edat, keep;
    longint sni, sdat;
    frame_t f;
    eop = STK_NONE; eni = 0; edat = '0; eaddr = -1;
    if (op == OP_CALL) begin
      if (frames.size() == NF) est = RSP_FRAME_OVERFLOW;
      else if (args > vals.size() - lim) est = RSP_BAD_ARGS;
      else begin
        est = RSP_OK;
        frames.push_back('{lim, addr});
        lim = vals.size() - args;
      end
      elat = est == RSP_OK ? 2 : 1;
    end else begin
      if (frames.size() == 0) est = RSP_FRAME_UNDERFLOW;
      else if (RCHK && vals.size() - lim != int'(res)) est = RSP_BAD_RESULTS;
      else begin
        f = frames.pop_back();
        keep = vals.size() > 0 ? vals[$] : '0;
        eop = res ? STK_INDEX_RESET_AND_PUSH : STK_INDEX_RESET;
        eni = lim;
        edat = res ? keep : '0;
        eaddr = f.addr;
        if (res && lim >= CAP) est = RSP_STACK_ERROR;
        else begin
          while (vals.size() > lim) void'(vals.pop_back());
          if (res) vals.push_back(keep);
          est = RSP_OK;
        end
        lim = f.lim;
      end
      elat = est == RSP_OK || est == RSP_STACK_ERROR ? 4 : 1;
    end
    req_valid = 1'b1; req_op = op; req_args = IW'(args); req_results = res; req_ret_addr = AW'(addr);
    tick();
    req_valid = 1'b0; req_op = 1'b0; req_args = '0; req_results = 1'b0; req_ret_addr = '0;
    n = 1; sop = STK_NONE; sni = 0; sdat = 0;
    while (!rsp_valid && n < 12) begin
      if (stk_op != STK_NONE) begin sop = stk_op; sni = stk_new_index; sdat = stk_data; end
      tick();
      n++;
    end
    check("rsp_seen", rsp_valid, 1);
    check("latency", n, elat);
    check("status", rsp_status, est);
    check("stk_op", sop, eop);
    check("new_index", sni, eni);
    check("stk_data", sdat, edat);
    if (eaddr >= 0) check("ret_addr", rsp_ret_addr, eaddr);
    check("limit", stk_underflow_limit, lim);
    check("index", stk_index, vals.size());
    if (vals.size() > 0) check("top", stk_out, vals[$]);
    tick();
    check("ready", req_ready, 1);
    check("rsp_pulse", rsp_valid, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int r, avail;
    tick();
    tick();
    check("rst_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_status", rsp_status, RSP_OK);
    check("rst_rsp_addr", rsp_ret_addr, 0);
    check("rst_limit", stk_underflow_limit, 0);
    check("rst_busy", stk_busy, 0);
    check("rst_stk_op", stk_op, STK_NONE);
    reset = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) tb_push(i);
    do_req(OP_CALL, 2, 1'b0, 'h40);
    tb_push(7);
    tb_push(9);
    do_req(OP_RETURN, 0, 1'b1, 0);
    do_req(OP_RETURN, 0, 1'b0, 0);
    do_reset();
    tb_push(11);
    do_req(OP_CALL, 2, 1'b0, 'h55);
    for (int i = 0; i < NF; i++) do_req(OP_CALL, 0, 1'b0, 'h100 + i * 3);
    do_req(OP_CALL, 0, 1'b0, 'h777);
    for (int i = 0; i < NF; i++) do_req(OP_RETURN, 0, 1'b0, 0);
    do_reset();
    tb_push(1);
    do_req(OP_CALL, 0, 1'b0, 'h21);
    tb_push(2);
    tb_push(3);
    do_req(OP_RETURN, 0, 1'b1, 0);
    do_reset();
    repeat (400) begin
      r = $urandom_range(0, 9);
      avail = vals.size() - lim;
      if (r < 4 && vals.size() < 100) tb_push($urandom);
      else if (r < 7) do_req(OP_CALL, $urandom_range(0, avail + 1), 1'b0, $urandom_range(0, 65535));
      else do_req(OP_RETURN, 0, 1'($urandom_range(0, 1)), 0);
    end
    do_reset();
    for (int i = 0; i < CAP; i++) tb_push($urandom);
    do_req(OP_CALL, 0, 1'b0, 'h99);
    do_req(OP_RETURN, 0, 1'b1, 0);
    do_reset();
    tb_push(5);
    tb_push(6);
    do_req(OP_CALL, 1, 1'b0, 'h33);
    req_valid = 1'b1; req_op = OP_RETURN; req_results = 1'b1;
    tick();
    req_valid = 1'b0; req_op = 1'b0; req_results = 1'b0;
    tick();
    check("trim_op", stk_op, STK_INDEX_RESET_AND_PUSH);
    reset = 1'b1;
    tick();
    check("abort_ready", req_ready, 1);
    check("abort_limit", stk_underflow_limit, 0);
    check("abort_rsp", rsp_valid, 0);
    check("abort_busy", stk_busy, 0);
    reset = 1'b0;
    frames.delete();
    vals.delete();
    lim = 0;
    tick();
    check("abort_no_rsp", rsp_valid, 0);
    do_req(OP_RETURN, 0, 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/call_frame_ctrl.md
# call_frame_ctrl

Call/return sequencer for the `SuperStack` operand stack. It turns WebAssembly-style CALL and RETURN requests into `SuperStack` operations: it moves the underflow limit to fence each callee's frame and trims the stack on return while preserving results. It also keeps a private frame memory of saved limits and return addresses. It sits between the instruction decoder and the operand stack; the top level muxes the stack's control ports to this block while `stk_busy` is high.

## Interface
Parameters:
- `WIDTH`, 32, operand width, equal to the stack's WIDTH
- `DEPTH`, 7, stack depth exponent, equal to the stack's DEPTH; indices are DEPTH+1 bits
- `FRAMES`, 5, frame memory depth exponent; capacity is 2^FRAMES frames
- `ADDR_WIDTH`, 16, return address width

Ports:
- `clk`  in  1  single clock; the block is fully synchronous.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_op`  in  1  0=CALL, 1=RETURN.
- `req_args`  in  DEPTH+1  CALL: number of arguments already on the stack.
- `req_results`  in  1  RETURN: callee leaves one result.
- `req_ret_addr`  in  ADDR_WIDTH  CALL: address to resume at.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_status`  out  3  completion code.
- `rsp_ret_addr`  out  ADDR_WIDTH  RETURN: popped return address.
- `stk_busy`  out  1  the block owns the stack control ports.
- `stk_op`  out  3  stack op, using the existing op macros.
- `stk_data`  out  WIDTH  stack data.
- `stk_new_index`  out  DEPTH+1  stack new_index.
- `stk_underflow_limit`  out  DEPTH+1  current frame base; always driven.
- `stk_index`  in  DEPTH+1  stack index.
- `stk_out`  in  WIDTH  stack top of stack.
- `stk_status`  in  3  stack status.

## Operation
- State machine states: IDLE, CALL_SET, RET_FETCH, RET_TRIM, RET_DONE, RESP.
- Reset values:
  - IDLE; frame count 0.
  - `stk_underflow_limit`=0, `stk_op`=NONE, `stk_busy`=0.
  - `rsp_valid`=0, `rsp_status`=OK, `rsp_ret_addr`=0.
- Reset mid-operation aborts the request with no response and discards all frames. The stack is reset by the same `reset`.
- Requests are accepted on `req_valid & req_ready`. Inputs and `stk_index` are latched at acceptance.
- CALL checks run in order; the first failing check wins:
  - frame count = 2^FRAMES → FRAME_OVERFLOW
  - `req_args` > `stk_index` − limit → BAD_ARGS
  - otherwise, in CALL_SET: push {limit, ret_addr} and set limit = `stk_index` − `req_args`; status OK.
  - Failed CALLs go straight to RESP with state unchanged.
- RETURN:
  - frame count 0 → FRAME_UNDERFLOW, go to RESP.
  - RET_FETCH: drive NONE so `stk_out` refreshes.
  - RET_TRIM, with results: capture `stk_out`, drive INDEX_RESET_AND_PUSH, `stk_new_index`=limit, `stk_data`=captured value.
  - RET_TRIM, no results: drive INDEX_RESET with `stk_new_index`=limit.
  - RET_TRIM, always: pop the frame and restore limit to the saved value.
  - RET_DONE: if `stk_status` is OVERFLOW or BAD_INDEX → STACK_ERROR, else OK. `rsp_ret_addr` = saved address.
- Error codes: OK=0, FRAME_OVERFLOW=1, FRAME_UNDERFLOW=2, BAD_ARGS=3, BAD_RESULTS=4, STACK_ERROR=5.
- Arithmetic is unsigned DEPTH+1-bit. Check `req_args` against `stk_index` − limit before subtracting, so no wrap occurs.
- `stk_busy` is high in all non-IDLE states except RESP. Whenever the block drives the stack, unused stack inputs are zero.

## Timing
- CALL: accept in cycle 0, CALL_SET in cycle 1, `rsp_valid` in cycle 2. The new limit is visible from cycle 2.
- Failed request: `rsp_valid` in cycle 1.
- RETURN: accept in cycle 0, RET_FETCH in cycle 1, RET_TRIM in cycle 2, RET_DONE in cycle 3 (samples `stk_status`), `rsp_valid` in cycle 4.
- Back-to-back: `req_ready` rises the cycle after RESP. There is no response backpressure.

## Configuration
- `CALL_FRAME_RESULT_CHECK_EN`, when defined: RETURN requires `stk_index` − limit == `req_results`.
  - On mismatch: RESP with BAD_RESULTS; no stack op is issued and the frame is kept.
  - The check runs at acceptance.
- When not defined: any excess values above the frame base are silently discarded by the index reset.

## Structure
- Shared package (`CallFrame.vh`, alongside `SuperStack.vh`): request op codes, `rsp_status` codes, state encodings.
- Op encodings come from the existing stack op macros.
- One sub-module, `frame_mem`: a synchronous LIFO of {limit, ret_addr} entries, 2^FRAMES deep, with push/pop/top and a count output.

## Test plan
- Stack index 5, limit 0, CALL args=2 ret=0x40 → cycle 2 `rsp_valid`, status OK, `stk_underflow_limit`=3.
- Then push 7, 9 (index 7), RETURN results=1 → stack receives INDEX_RESET_AND_PUSH with new_index 3, data 9.
  - Final index 4, top 9, limit 0, `rsp_ret_addr`=0x40, cycle 4 response.
- RETURN with no frames → cycle 1 FRAME_UNDERFLOW; `stk_op` stays NONE.
- Index 1, limit 0, CALL args=2 → BAD_ARGS; limit unchanged.
- Fill 2^FRAMES frames, then CALL → FRAME_OVERFLOW.
  - Then 2^FRAMES RETURNs restore every return address in LIFO order.
- With `CALL_FRAME_RESULT_CHECK_EN`: frame holding 2 values, RETURN results=1 → BAD_RESULTS, index unchanged.
  - Same RETURN with the macro undefined → OK, index = base + 1.
- Assert `reset` during RET_TRIM → next cycle IDLE, limit 0, no `rsp_valid`.
